// File: rtl/dsp_nco_pkg.sv
// Shared constants for the NCO control blocks.
// State encodings and sweep mode values.
package dsp_nco_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sweep_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_LOOP    = 1'b1;

endpackage

// File: rtl/dsp_nco_sweep_ctrl.sv
// Stepped linear chirp sequencer feeding dsp_nco en / phi_inc.
// Holds each FCW for dwell+1 cycles; one-shot or looped sweeps.
module dsp_nco_sweep_ctrl
    import dsp_nco_pkg::*;
#(
    parameter int PHI_WIDTH   = 32,
    parameter int STEP_WIDTH  = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHI_WIDTH-1:0]   cfg_start_fcw,
    input  logic [PHI_WIDTH-1:0]   cfg_step_fcw,
    input  logic [STEP_WIDTH-1:0]  cfg_num_steps,
    input  logic [DWELL_WIDTH-1:0] cfg_dwell,
    input  logic                   cfg_loop,
    output logic                   nco_en,
    output logic [PHI_WIDTH-1:0]   nco_phi_inc,
    output logic                   busy,
    output logic                   done,
    output logic [STEP_WIDTH-1:0]  step_idx
);

    sweep_state_e           state_q, state_d;
    logic [PHI_WIDTH-1:0]   start_fcw_q, start_fcw_d;
    logic [PHI_WIDTH-1:0]   step_fcw_q, step_fcw_d;
    logic [STEP_WIDTH-1:0]  num_steps_q, num_steps_d;
    logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
    logic                   loop_q, loop_d;
    logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [STEP_WIDTH-1:0]  step_idx_q, step_idx_d;
    logic [PHI_WIDTH-1:0]   phi_q, phi_d;
    logic                   en_q, en_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Next-state, shadow capture and sweep stepping.
    always_comb begin
        state_d     = state_q;
        start_fcw_d = start_fcw_q;
        step_fcw_d  = step_fcw_q;
        num_steps_d = num_steps_q;
        dwell_d     = dwell_q;
        loop_d      = loop_q;
        dwell_cnt_d = dwell_cnt_q;
        step_idx_d  = step_idx_q;
        phi_d       = phi_q;
        en_d        = en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                en_d        = 1'b0;
                busy_d      = 1'b0;
                phi_d       = '0;
                step_idx_d  = '0;
                dwell_cnt_d = '0;
                if (start && !abort) begin
                    state_d     = ST_RUN;
                    start_fcw_d = cfg_start_fcw;
                    step_fcw_d  = cfg_step_fcw;
                    num_steps_d = cfg_num_steps;
                    dwell_d     = cfg_dwell;
                    loop_d      = cfg_loop;
                    en_d        = 1'b1;
                    busy_d      = 1'b1;
                    phi_d       = cfg_start_fcw;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    en_d        = 1'b0;
                    busy_d      = 1'b0;
                    phi_d       = '0;
                    step_idx_d  = '0;
                    dwell_cnt_d = '0;
                end else if (dwell_cnt_q == dwell_q) begin
                    dwell_cnt_d = '0;
                    if (step_idx_q < num_steps_q) begin
                        phi_d      = phi_q + step_fcw_q;
                        step_idx_d = step_idx_q + 1'b1;
                    end else if (loop_q == MODE_LOOP) begin
                        phi_d      = start_fcw_q;
                        step_idx_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        en_d       = 1'b0;
                        busy_d     = 1'b0;
                        phi_d      = '0;
                        step_idx_d = '0;
                        done_d     = 1'b1;
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            start_fcw_q <= '0;
            step_fcw_q  <= '0;
            num_steps_q <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            dwell_cnt_q <= '0;
            step_idx_q  <= '0;
            phi_q       <= '0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_fcw_q <= start_fcw_d;
            step_fcw_q  <= step_fcw_d;
            num_steps_q <= num_steps_d;
            dwell_q     <= dwell_d;
            loop_q      <= loop_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_idx_q  <= step_idx_d;
            phi_q       <= phi_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign nco_en      = en_q;
    assign nco_phi_inc = phi_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign step_idx    = step_idx_q;

endmodule

// File: tb/tb_dsp_nco_sweep_ctrl.sv
// Self-checking bench for dsp_nco_sweep_ctrl.
// Expected tones come from start + k*step arithmetic per tone.
module tb_dsp_nco_sweep_ctrl;

    typedef struct {
        logic [31:0] sfcw;
        logic [31:0] step;
        int          nsteps;
        int          dwell;
        logic        loop;
    } cfg_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] cfg_start_fcw = '0;
    logic [31:0] cfg_step_fcw = '0;
    logic [15:0] cfg_num_steps = '0;
    logic [15:0] cfg_dwell = '0;
    logic        cfg_loop = 1'b0;
    logic        nco_en;
    logic [31:0] nco_phi_inc;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    int checks = 0;
    int errors = 0;

    dsp_nco_sweep_ctrl #(
        .PHI_WIDTH(32),
        .STEP_WIDTH(16),
        .DWELL_WIDTH(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .abort(abort),
        .cfg_start_fcw(cfg_start_fcw),
        .cfg_step_fcw(cfg_step_fcw),
        .cfg_num_steps(cfg_num_steps),
        .cfg_dwell(cfg_dwell),
        .cfg_loop(cfg_loop),
        .nco_en(nco_en),
        .nco_phi_inc(nco_phi_inc),
        .busy(busy),
        .done(done),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] tone_fcw(cfg_t c, int k);
        logic [63:0] p;
        p = 64'(c.sfcw) + 64'(c.step) * 64'(k);
        return p[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_start(cfg_t c);
        cfg_start_fcw = c.sfcw;
        cfg_step_fcw  = c.step;
        cfg_num_steps = 16'(c.nsteps);
        cfg_dwell     = 16'(c.dwell);
        cfg_loop      = c.loop;
        abort         = 1'b0;
        start         = 1'b1;
    endtask

    task automatic scramble();
        start         = 1'($urandom);
        cfg_start_fcw = $urandom;
        cfg_step_fcw  = $urandom;
        cfg_num_steps = 16'($urandom);
        cfg_dwell     = 16'($urandom);
        cfg_loop      = 1'($urandom);
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, "_en"}, 64'(nco_en), 64'(0));
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_phi"}, 64'(nco_phi_inc), 64'(0));
        check({tag, "_idx"}, 64'(step_idx), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(exp_done));
    endtask

    // Start must already be applied; checks every enabled cycle and done.
    task automatic run_oneshot(input string tag, cfg_t c, input bit noisy,
                               input bit chain, cfg_t nc);
        tick();
        start = 1'b0;
        for (int k = 0; k <= c.nsteps; k++) begin
            for (int d = 0; d <= c.dwell; d++) begin
                check({tag, "_en"}, 64'(nco_en), 64'(1));
                check({tag, "_busy"}, 64'(busy), 64'(1));
                check({tag, "_phi"}, 64'(nco_phi_inc), 64'(tone_fcw(c, k)));
                check({tag, "_idx"}, 64'(step_idx), 64'(k));
                check({tag, "_done"}, 64'(done), 64'(0));
                if (noisy) scramble();
                tick();
            end
        end
        start = 1'b0;
        check_idle({tag, "_end"}, 1'b1);
        if (chain) begin
            apply_start(nc);
        end else begin
            tick();
            check_idle({tag, "_post"}, 1'b0);
        end
    endtask

    function automatic cfg_t rand_cfg(input bit loop);
        cfg_t c;
        c.sfcw   = $urandom;
        c.step   = $urandom;
        c.nsteps = int'($urandom_range(0, 5));
        c.dwell  = int'($urandom_range(0, 3));
        c.loop   = loop;
        return c;
    endfunction

    initial begin
        cfg_t c1, c2, c3, cl, cr;
        c1 = '{32'h1000_0000, 32'h0100_0000, 3, 1, 1'b0};
        c2 = '{32'h0080_0000, 32'hFF00_0000, 1, 0, 1'b0};
        c3 = '{32'h1234_5678, 32'h0000_0010, 0, 0, 1'b0};
        cl = '{32'd5, 32'd1, 2, 0, 1'b1};

        #2;
        check_idle("reset_async", 1'b0);
        tick();
        check_idle("reset", 1'b0);
        rst_n = 1'b1;
        tick();

        apply_start(c1);
        run_oneshot("oneshot", c1, 1'b0, 1'b0, c1);
        apply_start(c2);
        run_oneshot("wrap", c2, 1'b0, 1'b0, c2);
        apply_start(c3);
        run_oneshot("minimal", c3, 1'b0, 1'b0, c3);

        apply_start(cl);
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            check("loop_en", 64'(nco_en), 64'(1));
            check("loop_phi", 64'(nco_phi_inc), 64'(tone_fcw(cl, i % 3)));
            check("loop_idx", 64'(step_idx), 64'(i % 3));
            check("loop_done", 64'(done), 64'(0));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("loop_abort", 1'b0);
        tick();
        check_idle("loop_abort2", 1'b0);

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check_idle("start_abort", 1'b0);

        for (int r = 0; r < 4; r++) begin
            cr = rand_cfg(1'b0);
            apply_start(cr);
            run_oneshot("rand_noisy", cr, 1'b1, 1'b0, cr);
        end

        cr = rand_cfg(1'b0);
        c3 = rand_cfg(1'b0);
        apply_start(cr);
        run_oneshot("b2b_a", cr, 1'b0, 1'b1, c3);
        run_oneshot("b2b_b", c3, 1'b0, 1'b0, c3);

        cr = rand_cfg(1'b1);
        cr.nsteps = 3;
        apply_start(cr);
        tick();
        start = 1'b0;
        for (int i = 0; i < 3 * (cr.nsteps + 1) * (cr.dwell + 1); i++) begin
            int k;
            k = (i / (cr.dwell + 1)) % (cr.nsteps + 1);
            check("rloop_phi", 64'(nco_phi_inc), 64'(tone_fcw(cr, k)));
            check("rloop_done", 64'(done), 64'(0));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("rloop_abort", 1'b0);

        apply_start(c1);
        tick();
        start = 1'b0;
        tick();
        check("pre_rst_en", 64'(nco_en), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset", 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("after_reset", 1'b0);
        apply_start(c1);
        run_oneshot("oneshot_again", c1, 1'b0, 1'b0, c1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
